// File: rtl/hpi_responder.sv
// Device-side HPI responder: synchronized strobe decode, pointer-addressed word RAM and mailboxes.
// Build option HPI_AUTOINC_EN: every DATA access post-increments the pointer by 2.
module hpi_responder #(
    parameter int ADDR_W      = 10,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  hpi_address,
    input  logic        hpi_cs_n,
    input  logic        hpi_r_n,
    input  logic        hpi_w_n,
    input  logic        hpi_reset_n,
    input  logic [15:0] hpi_data_in,
    output logic [15:0] hpi_data_out,
    output logic        hpi_data_oe,
    output logic        mbx_in_valid,
    output logic [15:0] mbx_in_data,
    input  logic        mbx_in_ack,
    input  logic        mbx_out_wr,
    input  logic [15:0] mbx_out_data,
    output logic        irq
);
    // state    | meaning
    // IDLE     | waiting for a qualified strobe edge
    // WR       | write commit cycle
    // WR_WAIT  | waiting for w_n or cs_n release
    // RD       | latch read mux, raise oe
    // RD_HOLD  | drive read data until r_n or cs_n release
    // ERR_WAIT | both strobes seen low; wait until both are high
    typedef enum logic [2:0] {IDLE, WR, WR_WAIT, RD, RD_HOLD, ERR_WAIT} state_t;

    localparam logic [1:0] PORT_DATA = 2'd0;
    localparam logic [1:0] PORT_MBX  = 2'd1;
    localparam logic [1:0] PORT_ADDR = 2'd2;
`ifdef HPI_AUTOINC_EN
    localparam logic [15:0] PTR_STEP = 16'd2;
`else
    localparam logic [15:0] PTR_STEP = 16'd0;
`endif
    localparam int SW = 22;
    localparam logic [SW-1:0] SYNC_IDLE = {4'b1111, 18'b0};

    logic [SW-1:0] sync_q [SYNC_STAGES];
    logic          hrst_s, cs_s, r_s, w_s;
    logic [1:0]    addr_s;
    logic [15:0]   din_s;
    logic          r_prev, w_prev;
    state_t        state_q, state_d;

    logic [15:0]   ptr_q;
    logic          err_q, ovr_q, mbx_out_full;
    logic [15:0]   mbx_out_word;
    logic [15:0]   rd_word;
    logic [15:0]   mem [2**ADDR_W];
    logic          wr_commit, rd_latch, rd_release, err_set;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= SYNC_IDLE;
            r_prev <= 1'b1;
            w_prev <= 1'b1;
        end else begin
            sync_q[0] <= {hpi_reset_n, hpi_cs_n, hpi_r_n, hpi_w_n, hpi_address, hpi_data_in};
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            r_prev <= r_s;
            w_prev <= w_s;
        end
    end

    assign {hrst_s, cs_s, r_s, w_s, addr_s, din_s} = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset)       state_q <= IDLE;
        else if (!hrst_s) state_q <= IDLE;
        else             state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (!cs_s) begin
                    if (!r_s && !w_s)            state_d = ERR_WAIT;
                    else if (w_prev && !w_s && r_s) state_d = WR;
                    else if (r_prev && !r_s && w_s) state_d = RD;
                end
            end
            WR:       state_d = WR_WAIT;
            WR_WAIT:  if (w_s || cs_s) state_d = IDLE;
            RD:       state_d = RD_HOLD;
            RD_HOLD:  if (r_s || cs_s) state_d = IDLE;
            ERR_WAIT: if (r_s && w_s) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    assign wr_commit  = (state_q == WR);
    assign rd_latch   = (state_q == RD);
    assign rd_release = (state_q == RD_HOLD) && (state_d == IDLE);
    assign err_set    = (state_q == IDLE) && (state_d == ERR_WAIT);
    assign irq        = mbx_out_full;

    // RAM contents survive both resets; only the pointer is cleared.
    always_ff @(posedge clk) begin
        if (wr_commit && hrst_s && addr_s == PORT_DATA) mem[ptr_q[ADDR_W:1]] <= din_s;
        rd_word <= mem[ptr_q[ADDR_W:1]];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q        <= '0;
            err_q        <= 1'b0;
            ovr_q        <= 1'b0;
            mbx_in_valid <= 1'b0;
            mbx_in_data  <= '0;
            mbx_out_full <= 1'b0;
            mbx_out_word <= '0;
            hpi_data_out <= '0;
            hpi_data_oe  <= 1'b0;
        end else if (!hrst_s) begin
            ptr_q        <= '0;
            err_q        <= 1'b0;
            ovr_q        <= 1'b0;
            mbx_in_valid <= 1'b0;
            mbx_in_data  <= '0;
            mbx_out_full <= 1'b0;
            mbx_out_word <= '0;
            hpi_data_out <= '0;
            hpi_data_oe  <= 1'b0;
        end else begin
            if (err_set) err_q <= 1'b1;
            if (mbx_in_ack) mbx_in_valid <= 1'b0;
            if (wr_commit) begin
                case (addr_s)
                    PORT_DATA: ptr_q <= ptr_q + PTR_STEP;
                    PORT_MBX: begin
                        mbx_in_data  <= din_s;
                        mbx_in_valid <= 1'b1;
                        if (mbx_in_valid && !mbx_in_ack) ovr_q <= 1'b1;
                    end
                    PORT_ADDR: ptr_q <= din_s;
                    default: begin
                        if (din_s[2]) ovr_q <= 1'b0;
                        if (din_s[3]) err_q <= 1'b0;
                    end
                endcase
            end
            if (rd_latch) begin
                hpi_data_oe <= 1'b1;
                case (addr_s)
                    PORT_DATA: begin
                        hpi_data_out <= rd_word;
                        ptr_q        <= ptr_q + PTR_STEP;
                    end
                    PORT_MBX: begin
                        hpi_data_out <= mbx_out_word;
                        mbx_out_full <= 1'b0;
                    end
                    PORT_ADDR: hpi_data_out <= ptr_q;
                    default:   hpi_data_out <= {12'b0, err_q, ovr_q, mbx_in_valid, mbx_out_full};
                endcase
            end else if (rd_release) begin
                hpi_data_oe <= 1'b0;
            end
            // A device post in the read-latch cycle overrides the clear above.
            if (mbx_out_wr) begin
                mbx_out_full <= 1'b1;
                mbx_out_word <= mbx_out_data;
            end
        end
    end
endmodule

// File: tb/tb_hpi_responder.sv
// Self-checking bench for hpi_responder: directed HPI transactions plus a randomized phase
// checked against a transaction-level model of the port, pointer, RAM and mailboxes.
module tb_hpi_responder;
    localparam int ADDR_W      = 10;
    localparam int SYNC_STAGES = 2;
`ifdef HPI_AUTOINC_EN
    localparam logic [15:0] STEP = 16'd2;
`else
    localparam logic [15:0] STEP = 16'd0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  hpi_address = 2'd0;
    logic        hpi_cs_n = 1'b1;
    logic        hpi_r_n = 1'b1;
    logic        hpi_w_n = 1'b1;
    logic        hpi_reset_n = 1'b1;
    logic [15:0] hpi_data_in = 16'h0;
    logic [15:0] hpi_data_out;
    logic        hpi_data_oe;
    logic        mbx_in_valid;
    logic [15:0] mbx_in_data;
    logic        mbx_in_ack = 1'b0;
    logic        mbx_out_wr = 1'b0;
    logic [15:0] mbx_out_data = 16'h0;
    logic        irq;

    int checks = 0;
    int errors = 0;

    logic [15:0] m_mem [2**ADDR_W];
    bit          m_known [2**ADDR_W];
    logic [15:0] m_ptr, m_in_data, m_out_word;
    bit          m_in_valid, m_out_full, m_err, m_ovr;

    hpi_responder #(.ADDR_W(ADDR_W), .SYNC_STAGES(SYNC_STAGES)) dut (
        .clk(clk), .reset(reset), .hpi_address(hpi_address), .hpi_cs_n(hpi_cs_n),
        .hpi_r_n(hpi_r_n), .hpi_w_n(hpi_w_n), .hpi_reset_n(hpi_reset_n),
        .hpi_data_in(hpi_data_in), .hpi_data_out(hpi_data_out), .hpi_data_oe(hpi_data_oe),
        .mbx_in_valid(mbx_in_valid), .mbx_in_data(mbx_in_data), .mbx_in_ack(mbx_in_ack),
        .mbx_out_wr(mbx_out_wr), .mbx_out_data(mbx_out_data), .irq(irq)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed still-running expected finished");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int m_idx();
        return int'(m_ptr[ADDR_W:1]);
    endfunction

    function automatic logic [15:0] m_status();
        return {12'b0, m_err, m_ovr, m_in_valid, m_out_full};
    endfunction

    task automatic m_reset();
        m_ptr = 16'h0; m_in_data = 16'h0; m_out_word = 16'h0;
        m_in_valid = 0; m_out_full = 0; m_err = 0; m_ovr = 0;
    endtask

    task automatic check_side(input string tag);
        check({tag, "_irq"}, {15'b0, irq}, {15'b0, m_out_full});
        check({tag, "_in_valid"}, {15'b0, mbx_in_valid}, {15'b0, m_in_valid});
        check({tag, "_in_data"}, mbx_in_data, m_in_data);
    endtask

    task automatic hpi_write(input logic [1:0] a, input logic [15:0] d, input bit inj_ack);
        case (a)
            2'd0: begin m_mem[m_idx()] = d; m_known[m_idx()] = 1; m_ptr = m_ptr + STEP; end
            2'd1: begin if (m_in_valid && !inj_ack) m_ovr = 1; m_in_valid = 1; m_in_data = d; end
            2'd2: m_ptr = d;
            default: begin if (d[2]) m_ovr = 0; if (d[3]) m_err = 0; end
        endcase
        @(posedge clk); #1;
        hpi_address = a; hpi_data_in = d; hpi_cs_n = 1'b0;
        @(posedge clk); #1 hpi_w_n = 1'b0;
        repeat (SYNC_STAGES + 1) @(posedge clk);
        #1 if (inj_ack) mbx_in_ack = 1'b1;
        @(posedge clk); #1 mbx_in_ack = 1'b0;
        repeat (SYNC_STAGES + 2) @(posedge clk);
        #1 hpi_w_n = 1'b1;
        repeat (SYNC_STAGES + 3) @(posedge clk);
        #1 hpi_cs_n = 1'b1;
        @(posedge clk);
    endtask

    task automatic hpi_read(input logic [1:0] a, input string tag, input bit inj, input logic [15:0] inj_word);
        logic [15:0] exp;
        bit          do_chk;
        do_chk = 1;
        case (a)
            2'd0: begin exp = m_mem[m_idx()]; do_chk = m_known[m_idx()]; m_ptr = m_ptr + STEP; end
            2'd1: begin exp = m_out_word; m_out_full = 0; end
            2'd2: exp = m_ptr;
            default: exp = m_status();
        endcase
        if (inj) begin m_out_full = 1; m_out_word = inj_word; end
        @(posedge clk); #1;
        hpi_address = a; hpi_cs_n = 1'b0;
        @(posedge clk); #1 hpi_r_n = 1'b0;
        repeat (SYNC_STAGES + 1) @(posedge clk);
        #1 if (inj) begin mbx_out_wr = 1'b1; mbx_out_data = inj_word; end
        @(posedge clk); #1 mbx_out_wr = 1'b0;
        repeat (SYNC_STAGES + 2) @(posedge clk);
        #1 check({tag, "_oe_high"}, {15'b0, hpi_data_oe}, 16'h1);
        if (do_chk) check(tag, hpi_data_out, exp);
        hpi_r_n = 1'b1;
        repeat (SYNC_STAGES + 3) @(posedge clk);
        #1 check({tag, "_oe_low"}, {15'b0, hpi_data_oe}, 16'h0);
        hpi_cs_n = 1'b1;
        @(posedge clk);
    endtask

    task automatic dev_post(input logic [15:0] d);
        @(posedge clk); #1 mbx_out_wr = 1'b1; mbx_out_data = d;
        @(posedge clk); #1 mbx_out_wr = 1'b0;
        m_out_full = 1; m_out_word = d;
    endtask

    task automatic dev_ack();
        @(posedge clk); #1 mbx_in_ack = 1'b1;
        @(posedge clk); #1 mbx_in_ack = 1'b0;
        m_in_valid = 0;
    endtask

    task automatic hpi_both();
        @(posedge clk); #1;
        hpi_address = 2'd0; hpi_data_in = 16'hDEAD; hpi_cs_n = 1'b0;
        @(posedge clk); #1 hpi_r_n = 1'b0; hpi_w_n = 1'b0;
        repeat (SYNC_STAGES + 4) @(posedge clk);
        #1 check("err_oe", {15'b0, hpi_data_oe}, 16'h0);
        hpi_r_n = 1'b1; hpi_w_n = 1'b1;
        repeat (SYNC_STAGES + 3) @(posedge clk);
        #1 hpi_cs_n = 1'b1;
        @(posedge clk);
        m_err = 1;
    endtask

    initial begin
        int          op;
        logic [31:0] r;
        m_reset();
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        repeat (SYNC_STAGES + 2) @(posedge clk);
        #1;
        check("rst_data_out", hpi_data_out, 16'h0);
        check("rst_oe", {15'b0, hpi_data_oe}, 16'h0);
        check_side("rst");
        hpi_read(2'd2, "rst_ptr", 0, 16'h0);
        hpi_read(2'd3, "rst_status", 0, 16'h0);

        // Pointer and RAM
        hpi_write(2'd2, 16'h1000, 0);
        hpi_write(2'd0, 16'hAAAA, 0);
        hpi_write(2'd0, 16'h5555, 0);
        hpi_write(2'd2, 16'h1000, 0);
        hpi_read(2'd0, "ram_rd0", 0, 16'h0);
        hpi_read(2'd0, "ram_rd1", 0, 16'h0);
        hpi_read(2'd2, "ram_ptr", 0, 16'h0);

        // Initiator-to-device mailbox, overrun, status clear, ack/commit coincidence
        hpi_write(2'd1, 16'h0051, 0);
        check_side("mbx_in1");
        hpi_write(2'd1, 16'h0052, 0);
        hpi_read(2'd3, "ovr_status", 0, 16'h0);
        hpi_write(2'd3, 16'h0004, 0);
        hpi_read(2'd3, "ovr_cleared", 0, 16'h0);
        hpi_write(2'd1, 16'h0077, 1);
        check_side("ack_coinc");
        hpi_read(2'd3, "ack_coinc_status", 0, 16'h0);
        dev_ack();
        check_side("acked");

        // Device-to-initiator mailbox
        dev_post(16'h1234);
        check_side("post");
        hpi_read(2'd3, "post_status", 0, 16'h0);
        hpi_read(2'd1, "mbx_out_rd", 0, 16'h0);
        check_side("post_rd");
        dev_post(16'hBEEF);
        hpi_read(2'd1, "coinc_rd_old", 1, 16'hCAFE);
        check_side("coinc_irq");
        hpi_read(2'd1, "coinc_rd_new", 0, 16'h0);
        check_side("coinc_drained");

        // Both strobes low together
        hpi_write(2'd2, 16'h0010, 0);
        hpi_write(2'd0, 16'h7E7E, 0);
        hpi_write(2'd2, 16'h0010, 0);
        hpi_both();
        hpi_read(2'd3, "err_status", 0, 16'h0);
        hpi_read(2'd2, "err_ptr", 0, 16'h0);
        hpi_read(2'd0, "err_ram", 0, 16'h0);
        hpi_write(2'd3, 16'h0008, 0);
        hpi_read(2'd3, "err_cleared", 0, 16'h0);

        // Pointer wrap and index aliasing of the upper pointer bits
        hpi_write(2'd2, 16'hFFFE, 0);
        hpi_write(2'd0, 16'h3C3C, 0);
        hpi_read(2'd2, "wrap_ptr", 0, 16'h0);
        hpi_write(2'd2, 16'h07FF, 0);
        hpi_read(2'd0, "alias_rd", 0, 16'h0);

        // HPI soft reset
        hpi_write(2'd2, 16'h0123, 0);
        hpi_write(2'd1, 16'h0042, 0);
        dev_post(16'h4321);
        @(posedge clk); #1 hpi_reset_n = 1'b0;
        repeat (SYNC_STAGES + 3) @(posedge clk);
        #1 m_reset();
        check_side("softrst");
        check("softrst_data_out", hpi_data_out, 16'h0);
        hpi_reset_n = 1'b1;
        repeat (SYNC_STAGES + 2) @(posedge clk);
        hpi_read(2'd2, "softrst_ptr", 0, 16'h0);
        hpi_read(2'd3, "softrst_status", 0, 16'h0);

        // Randomized traffic in a 16-word window with random ignored pointer bits
        for (int i = 0; i < 80; i++) begin
            op = int'($urandom_range(0, 9));
            r  = $urandom;
            case (op)
                0:       hpi_write(2'd2, {r[15:11], 6'b0, r[4:0]}, 0);
                1, 2:    hpi_write(2'd0, r[15:0], 0);
                3, 4:    hpi_read(2'd0, "rnd_data", 0, 16'h0);
                5:       hpi_read(2'd2, "rnd_ptr", 0, 16'h0);
                6:       hpi_read(2'd3, "rnd_status", 0, 16'h0);
                7:       if (r[16]) hpi_write(2'd1, r[15:0], 0); else dev_ack();
                8:       if (r[16]) dev_post(r[15:0]); else hpi_read(2'd1, "rnd_mbx", 0, 16'h0);
                default: hpi_write(2'd3, r[15:0], 0);
            endcase
            check_side("rnd");
        end

        // Hard reset during a read
        hpi_write(2'd2, 16'h0040, 0);
        hpi_write(2'd0, 16'h9999, 0);
        hpi_write(2'd2, 16'h0040, 0);
        @(posedge clk); #1 hpi_address = 2'd0; hpi_cs_n = 1'b0;
        @(posedge clk); #1 hpi_r_n = 1'b0;
        repeat (SYNC_STAGES + 4) @(posedge clk);
        #1 check("midrd_oe_before", {15'b0, hpi_data_oe}, 16'h1);
        #2 reset = 1'b1;
        #1 check("midrd_oe_async", {15'b0, hpi_data_oe}, 16'h0);
        check("midrd_data_out", hpi_data_out, 16'h0);
        hpi_r_n = 1'b1; hpi_cs_n = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        m_reset();
        repeat (SYNC_STAGES + 2) @(posedge clk);
        #1 check_side("midrd");
        hpi_read(2'd2, "midrd_ptr", 0, 16'h0);
        hpi_write(2'd2, 16'h0040, 0);
        hpi_read(2'd0, "midrd_ram_kept", 0, 16'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/hpi_responder.md
# hpi_responder

Synthesizable responder for the EZ-OTG Host Port Interface: the device end of the 2-bit-address, active-low strobe HPI bus that the NIOS II PIO exports drive. It decodes the DATA/MAILBOX/ADDRESS/STATUS ports, holds an internal word RAM behind an auto-incrementing address pointer, and exchanges mailbox words with a device-side agent. It is used as a CY7C67200 stand-in for bench and on-chip loopback testing of the keyboard driver.

## Interface

Parameters:
- ADDR_W, 10: RAM word-address width (1024 words); pointer bits [ADDR_W:1] index the RAM.
- SYNC_STAGES, 2: synchronizer depth on all HPI inputs; minimum 1.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- hpi_address  in  2  port select: 0 DATA, 1 MAILBOX, 2 ADDRESS, 3 STATUS.
- hpi_cs_n  in  1  chip select, active low.
- hpi_r_n  in  1  read strobe, active low.
- hpi_w_n  in  1  write strobe, active low.
- hpi_reset_n  in  1  HPI soft reset, active low.
- hpi_data_in  in  16  write data from initiator.
- hpi_data_out  out  16  read data to initiator.
- hpi_data_oe  out  1  high while responder drives read data.
- mbx_in_valid  out  1  initiator-written mailbox word pending.
- mbx_in_data  out  16  pending mailbox word.
- mbx_in_ack  in  1  device consumes mbx_in word.
- mbx_out_wr  in  1  device posts word to initiator.
- mbx_out_data  in  16  posted word.
- irq  out  1  high while mbx_out is full.

## Operation

- All HPI inputs pass through SYNC_STAGES flops; edges are detected on synchronized strobes, qualified by synchronized cs_n low.
- FSM states: IDLE, WR, WR_WAIT, RD, RD_HOLD, ERR_WAIT.
  - IDLE -> WR on w_n falling edge with cs_n low and r_n high.
  - IDLE -> RD on r_n falling edge with cs_n low and w_n high.
  - IDLE -> ERR_WAIT if r_n and w_n are both low with cs_n low; sets STATUS.err.
  - WR: commit for one cycle -> WR_WAIT. WR_WAIT -> IDLE once w_n or cs_n is high.
  - RD: latch read mux into hpi_data_out and assert hpi_data_oe -> RD_HOLD. RD_HOLD -> IDLE once r_n or cs_n is high; oe drops on that transition.
  - ERR_WAIT -> IDLE once both strobes are high.
- Write effects:
  - ADDRESS loads the 16-bit pointer.
  - DATA writes RAM[ptr[ADDR_W:1]], then applies the post-increment.
  - MAILBOX loads mbx_in_data and sets mbx_in_valid; if it was already set, also sets STATUS.ovr.
  - STATUS write of 1 to bit 2 or 3 clears that bit.
- Read effects:
  - ADDRESS returns the pointer.
  - DATA returns RAM[ptr], then applies the post-increment.
  - MAILBOX returns the mbx_out word and clears mbx_out full.
  - STATUS returns {12'b0, err, ovr, mbx_in_valid, mbx_out_full}.
- Pointer arithmetic is 16-bit modulo; ptr bit 0 is ignored for RAM indexing; the RAM index wraps at 2^ADDR_W words.
- mbx_in_ack clears mbx_in_valid. mbx_out_wr loads the word and sets mbx_out_full; irq = mbx_out_full.
- hpi_reset_n low (synchronized) behaves like reset for the pointer, flags, FSM and outputs. RAM contents are preserved.

## Timing

- Reset values: hpi_data_out 0, hpi_data_oe 0, mbx_in_valid 0, mbx_in_data 0, irq 0, pointer 0, all status bits 0, FSM IDLE.
- Write commit occurs SYNC_STAGES+1 clk cycles after the w_n fall.
- Read data is valid and oe high SYNC_STAGES+1 cycles after the r_n fall, held until strobe release + SYNC_STAGES + 1.
- RAM is synchronous-read. The pointer is stable in IDLE, so RD latches without an extra stall.
- Simultaneous events:
  - mbx_out_wr in the same cycle as a MAILBOX read latch: the read returns the old word; the set wins, so full stays 1 with the new word.
  - mbx_in_ack in the same cycle as a MAILBOX write commit: the set wins and ovr is not set.
- Reset asserted mid-transaction: the FSM returns to IDLE immediately and oe drops asynchronously.
- Post-increment occurs in the commit (WR) or latch (RD) cycle.

## Configuration

- HPI_AUTOINC_EN defined: every DATA access post-increments the pointer by 2.
- HPI_AUTOINC_EN undefined: the pointer changes only on ADDRESS writes or reset.

## Test plan

- Write ADDRESS=0x1000, DATA 0xAAAA, DATA 0x5555, then ADDRESS=0x1000 and two DATA reads -> 0xAAAA, 0x5555 with HPI_AUTOINC_EN. Without it, a single DATA read returns 0x5555.
- Initiator writes MAILBOX 0x0051 -> mbx_in_valid=1, mbx_in_data=0x0051. A second write before ack -> STATUS reads 0x0006. Writing STATUS 0x0004 -> reads 0x0002.
- Device mbx_out_wr 0x1234 -> irq=1, STATUS bit0=1. MAILBOX read -> 0x1234, then irq=0.
- mbx_out_wr coincident with the MAILBOX read latch cycle -> read returns old word, irq stays 1, next read returns new word.
- r_n and w_n low together with cs_n low -> no RAM or pointer change, STATUS=0x0008 after release.
- Pointer at 0xFFFE, DATA write with HPI_AUTOINC_EN -> pointer 0x0000. Assert reset mid-read -> hpi_data_oe=0 immediately, pointer 0, RAM content retained.
